// File: rtl/byte_pack_writer.sv
// Packs a framed 8-bit byte stream into 16-bit words, low byte first.
// Drives one registered write per word straight into a byte-enabled RAM.
//
// Ports:
//   clk, rst_n       clock and async active-low reset
//   start            opens a frame (honoured in IDLE only)
//   start_addr       first write address of the frame
//   in_data          stream byte
//   in_valid         in_data is valid
//   in_last          final byte of the frame
//   in_ready         a byte can be accepted this cycle
//   ram_we           one-cycle write strobe per word
//   ram_byte_ena     2'b11 full word, 2'b01 low byte only
//   ram_data         {hi, lo}
//   ram_addr         write address
//   done             one-cycle frame-end pulse
//   words_written    writes issued in the current or last frame
//   overflow         sticky, frame tried to exceed the RAM depth
module byte_pack_writer #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  ram_we,
  output logic [1:0]            ram_byte_ena,
  output logic [15:0]           ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t r_state;
  state_t w_next;

  logic [7:0]            r_lo;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_ovf;
  logic                  r_we;
  logic [1:0]            r_be;
  logic [15:0]           r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_done;

  logic w_ready;
  logic w_acc;
  logic w_word;
  logic w_full;
  logic w_wr;
  logic w_drop;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_LO;
      S_LO: begin
        if (w_acc)
          w_next = in_last ? S_IDLE : S_HI;
      end
      S_HI: begin
        if (w_acc)
          w_next = in_last ? S_IDLE : S_LO;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_ready = (r_state == S_LO) ||
              (r_state == S_HI);
    w_acc   = in_valid && w_ready;
    // A word completes on any HI byte, or
    // on a lone last byte in LO.
    w_word  = w_acc &&
              ((r_state == S_HI) ||
               ((r_state == S_LO) && in_last));
    w_full  = (r_cnt == DEPTH);
    w_wr    = w_word && !w_full;
    w_drop  = w_word && w_full;
  end

  // Datapath and registered RAM port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo   <= '0;
      r_ptr  <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_we   <= 1'b0;
      r_be   <= 2'b00;
      r_data <= '0;
      r_addr <= '0;
      r_done <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_be   <= 2'b00;
      r_data <= '0;
      r_done <= w_acc && in_last;
      if ((r_state == S_IDLE) && start) begin
        r_ptr <= start_addr;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end
      if (w_acc && (r_state == S_LO))
        r_lo <= in_data;
      if (w_wr) begin
        r_we   <= 1'b1;
        r_addr <= r_ptr;
        r_ptr  <= r_ptr + 1'b1;
        r_cnt  <= r_cnt + 1'b1;
        if (r_state == S_HI) begin
          r_be   <= 2'b11;
          r_data <= {in_data, r_lo};
        end else begin
          r_be   <= 2'b01;
          r_data <= {8'h00, in_data};
        end
      end
      if (w_drop)
        r_ovf <= 1'b1;
    end
  end

  assign in_ready      = w_ready;
  assign ram_we        = r_we;
  assign ram_byte_ena  = r_be;
  assign ram_data      = r_data;
  assign ram_addr      = r_addr;
  assign done          = r_done;
  assign words_written = r_cnt;
  assign overflow      = r_ovf;

endmodule

// File: tb/tb_byte_pack_writer.sv
// Directed bench for byte_pack_writer.
// Two instances: 8-bit address (A) and 2-bit address (B).
module tb_byte_pack_writer;

  logic        clk;
  logic        rst_n;
  logic        a_start;
  logic [7:0]  a_saddr;
  logic        b_start;
  logic [1:0]  b_saddr;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;

  logic        a_ready, a_we, a_done, a_ovf;
  logic [1:0]  a_be;
  logic [15:0] a_data;
  logic [7:0]  a_addr;
  logic [8:0]  a_cnt;

  logic        b_ready, b_we, b_done, b_ovf;
  logic [1:0]  b_be;
  logic [15:0] b_data;
  logic [1:0]  b_addr;
  logic [2:0]  b_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  byte_pack_writer #(.ADDR_WIDTH(8)) u_a (
    .clk(clk), .rst_n(rst_n),
    .start(a_start), .start_addr(a_saddr),
    .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(a_ready),
    .ram_we(a_we), .ram_byte_ena(a_be),
    .ram_data(a_data), .ram_addr(a_addr),
    .done(a_done), .words_written(a_cnt),
    .overflow(a_ovf)
  );

  byte_pack_writer #(.ADDR_WIDTH(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .start(b_start), .start_addr(b_saddr),
    .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(b_ready),
    .ram_we(b_we), .ram_byte_ena(b_be),
    .ram_data(b_data), .ram_addr(b_addr),
    .done(b_done), .words_written(b_cnt),
    .overflow(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s got %0h exp %0h",
                tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] d,
                      input logic l);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    in_data  = 8'hEE;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic a_go(input logic [7:0] ad);
    @(negedge clk);
    a_start = 1'b1;
    a_saddr = ad;
    @(posedge clk);
    #1;
    a_start = 1'b0;
  endtask

  task automatic a_wr(input string tag,
                      input logic [15:0] d,
                      input logic [1:0] be,
                      input logic [7:0] ad,
                      input logic dn,
                      input logic [8:0] cnt);
    chk({tag, ".we"},   32'(a_we),   32'd1);
    chk({tag, ".data"}, 32'(a_data), 32'(d));
    chk({tag, ".be"},   32'(a_be),   32'(be));
    chk({tag, ".addr"}, 32'(a_addr), 32'(ad));
    chk({tag, ".done"}, 32'(a_done), 32'(dn));
    chk({tag, ".cnt"},  32'(a_cnt),  32'(cnt));
  endtask

  task automatic a_nowr(input string tag);
    chk({tag, ".we"},   32'(a_we),   32'd0);
    chk({tag, ".be"},   32'(a_be),   32'd0);
    chk({tag, ".data"}, 32'(a_data), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    a_start  = 1'b0;
    a_saddr  = 8'h00;
    b_start  = 1'b0;
    b_saddr  = 2'd0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(a_ready), 32'd0);
    a_nowr("rst");
    chk("rst.addr", 32'(a_addr), 32'd0);
    chk("rst.done", 32'(a_done), 32'd0);
    chk("rst.cnt",  32'(a_cnt),  32'd0);
    chk("rst.ovf",  32'(a_ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Even frame
    a_go(8'h10);
    chk("ev.ready", 32'(a_ready), 32'd1);
    chk("ev.cnt0",  32'(a_cnt),   32'd0);
    send(8'h11, 1'b0);
    a_nowr("ev.b1");
    send(8'h22, 1'b0);
    a_wr("ev.w1", 16'h2211, 2'b11, 8'h10, 1'b0, 9'd1);
    send(8'h33, 1'b0);
    a_nowr("ev.b3");
    send(8'h44, 1'b1);
    a_wr("ev.w2", 16'h4433, 2'b11, 8'h11, 1'b1, 9'd2);
    chk("ev.rdy_end", 32'(a_ready), 32'd0);
    idle();
    a_nowr("ev.after");
    chk("ev.done0", 32'(a_done), 32'd0);
    chk("ev.hold",  32'(a_cnt),  32'd2);

    // in_valid in IDLE is ignored
    send(8'h99, 1'b1);
    a_nowr("idlev");
    chk("idlev.done", 32'(a_done), 32'd0);
    chk("idlev.cnt",  32'(a_cnt),  32'd2);

    // Odd frame
    a_go(8'h20);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    a_wr("od.w1", 16'hBBAA, 2'b11, 8'h20, 1'b0, 9'd1);
    send(8'hCC, 1'b1);
    a_wr("od.w2", 16'h00CC, 2'b01, 8'h21, 1'b1, 9'd2);

    // Wrap with backpressure
    a_go(8'hFF);
    send(8'h01, 1'b0);
    a_nowr("wr.b1");
    idle();
    a_nowr("wr.g1");
    send(8'h02, 1'b0);
    a_wr("wr.w1", 16'h0201, 2'b11, 8'hFF, 1'b0, 9'd1);
    idle();
    a_nowr("wr.g2");
    send(8'h03, 1'b0);
    a_nowr("wr.b3");
    idle();
    a_nowr("wr.g3");
    send(8'h04, 1'b1);
    a_wr("wr.w2", 16'h0403, 2'b11, 8'h00, 1'b1, 9'd2);
    idle();
    a_nowr("wr.end");

    // start in LO and in HI is ignored
    a_go(8'h40);
    a_go(8'h70);
    chk("st.lo.cnt", 32'(a_cnt), 32'd0);
    send(8'h55, 1'b0);
    a_go(8'h80);
    a_nowr("st.hi");
    send(8'h66, 1'b1);
    a_wr("st.w", 16'h6655, 2'b11, 8'h40, 1'b1, 9'd1);

    // Reset while in HI
    a_go(8'h50);
    send(8'h77, 1'b0);
    send(8'h78, 1'b0);
    send(8'h79, 1'b0);
    @(negedge clk);
    in_data  = 8'h88;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm.ready", 32'(a_ready), 32'd0);
    a_nowr("rm.now");
    chk("rm.addr", 32'(a_addr), 32'd0);
    chk("rm.cnt",  32'(a_cnt),  32'd0);
    chk("rm.done", 32'(a_done), 32'd0);
    @(posedge clk);
    #1;
    a_nowr("rm.edge");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    a_nowr("rm.rel");
    chk("rm.rdy2", 32'(a_ready), 32'd0);
    a_go(8'h60);
    send(8'h01, 1'b0);
    send(8'h02, 1'b1);
    a_wr("rm.w", 16'h0201, 2'b11, 8'h60, 1'b1, 9'd1);

    // Overflow on the 2-bit instance
    @(negedge clk);
    b_start = 1'b1;
    b_saddr = 2'd1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      send(8'(i), i == 10);
      if (i % 2 == 0 && i <= 8) begin
        chk($sformatf("ov%0d.we", i),
            32'(b_we), 32'd1);
        chk($sformatf("ov%0d.data", i),
            32'(b_data), 32'({8'(i), 8'(i - 1)}));
        chk($sformatf("ov%0d.addr", i),
            32'(b_addr), 32'((i / 2) % 4));
        chk($sformatf("ov%0d.cnt", i),
            32'(b_cnt), 32'(i / 2));
        chk($sformatf("ov%0d.ovf", i),
            32'(b_ovf), 32'd0);
      end else begin
        chk($sformatf("ov%0d.we", i),
            32'(b_we), 32'd0);
      end
    end
    chk("ov.ovf",  32'(b_ovf),  32'd1);
    chk("ov.cnt",  32'(b_cnt),  32'd4);
    chk("ov.done", 32'(b_done), 32'd1);
    chk("ov.be",   32'(b_be),   32'd0);
    idle();
    chk("ov.hold", 32'(b_ovf),  32'd1);
    chk("ov.d0",   32'(b_done), 32'd0);
    @(negedge clk);
    b_start = 1'b1;
    b_saddr = 2'd0;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    chk("ov.clr",  32'(b_ovf), 32'd0);
    chk("ov.cnt0", 32'(b_cnt), 32'd0);

    $display("%0d/%0d checks passed",
             n_pass, n_tot);
    $finish;
  end

endmodule
